// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control / M-extension block.
// Holds the base-ALU Operation codes, ALUOp encodings, Funct7 patterns,
// the M-op Funct3 enum and the multiply/divide FSM state type.
package alu_pkg;

  // Base-ALU Operation codes
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_SLTU  = 4'b0110;
  localparam logic [3:0] OP_CMP   = 4'b1000;
  localparam logic [3:0] OP_SLL   = 4'b1100;
  localparam logic [3:0] OP_SRL   = 4'b1101;
  localparam logic [3:0] OP_SRA   = 4'b1110;
  localparam logic [3:0] OP_PASSB = 4'b1111;

  // ALUOp encodings coming from the main decoder
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RI     = 2'b10;
  localparam logic [1:0] ALUOP_JUMP   = 2'b11;

  // Funct7 patterns of interest
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // M-extension operation selected by Funct3
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  // Multiply/divide sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  // True when the decode fields describe an R-type M-extension instruction
  function automatic logic is_md_op(input logic [1:0] alu_op, input logic rtype,
                                    input logic [6:0] funct7);
    return (alu_op == ALUOP_RI) && rtype && (funct7 == F7_MULDIV);
  endfunction

endpackage

// File: rtl/alu_ctrl_muldiv_if.sv
// Decode / M-extension bus between the pipeline and alu_ctrl_muldiv.
// master: pipeline side (drives decode fields and operands, reads results)
// slave : alu_ctrl_muldiv side
interface alu_ctrl_muldiv_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 4
);
  logic            valid_i;
  logic [1:0]      ALUOp;
  logic            RType;
  logic [6:0]      Funct7;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush_i;
  logic [OP_W-1:0] Operation;
  logic            stall_o;
  logic            md_valid_o;
  logic [XLEN-1:0] md_result_o;

  modport master (
    output valid_i, ALUOp, RType, Funct7, Funct3, src_a, src_b, flush_i,
    input  Operation, stall_o, md_valid_o, md_result_o
  );

  modport slave (
    input  valid_i, ALUOp, RType, Funct7, Funct3, src_a, src_b, flush_i,
    output Operation, stall_o, md_valid_o, md_result_o
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide datapath.
// Ports: clk, rst_n; start loads operands (as magnitudes) and clears the
// counter; step performs one shift-add or restoring-division iteration.
// cnt_last flags XLEN completed iterations, special flags divide-by-zero or
// signed overflow, result is the sign-corrected final value.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  md_op_e          op_in,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic            cnt_last,
  output logic            special,
  output logic [XLEN-1:0] result
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] x);
    return ~x + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  logic [CNT_W-1:0] cnt_r;
  md_op_e           op_r;
  logic [XLEN-1:0]  a_raw_r;
  logic [XLEN-1:0]  mag_b_r;
  logic [XLEN-1:0]  hi_r;        // product high half / partial remainder
  logic [XLEN-1:0]  lo_r;        // multiplier bits / quotient bits
  logic             neg_main_r;  // negate product or quotient
  logic             neg_rem_r;   // negate remainder
  logic             div_zero_r;
  logic             div_ovf_r;

  logic             a_neg_s, b_neg_s, a_signed_s, b_signed_s;
  logic             div_zero_s, div_ovf_s;
  logic [XLEN-1:0]  mag_a_s, mag_b_s;
  logic [XLEN:0]    mul_sum_s, div_shift_s, div_diff_s;
  logic [2*XLEN-1:0] prod_s, prod_neg_s;

  assign a_signed_s = (op_in == MD_MUL) || (op_in == MD_MULH) || (op_in == MD_MULHSU) ||
                      (op_in == MD_DIV) || (op_in == MD_REM);
  assign b_signed_s = (op_in == MD_MUL) || (op_in == MD_MULH) ||
                      (op_in == MD_DIV) || (op_in == MD_REM);
  assign a_neg_s    = a_signed_s & a_in[XLEN-1];
  assign b_neg_s    = b_signed_s & b_in[XLEN-1];
  assign mag_a_s    = a_neg_s ? neg_x(a_in) : a_in;
  assign mag_b_s    = b_neg_s ? neg_x(b_in) : b_in;
  assign div_zero_s = op_in[2] && (b_in == {XLEN{1'b0}});
  assign div_ovf_s  = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                      (a_in == {1'b1, {(XLEN-1){1'b0}}}) && (b_in == {XLEN{1'b1}});

  // Shift-add adds the multiplicand when the current multiplier bit is set
  assign mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mag_b_r} : {(XLEN+1){1'b0}});
  // Restoring division: shift in the next dividend bit, trial-subtract divisor
  assign div_shift_s = {hi_r, lo_r[XLEN-1]};
  assign div_diff_s  = div_shift_s - {1'b0, mag_b_r};

  assign prod_s     = {hi_r, lo_r};
  assign prod_neg_s = ~prod_s + {{(2*XLEN-1){1'b0}}, 1'b1};
  assign cnt_last   = (cnt_r == CNT_W'(XLEN));
  assign special    = div_zero_r | div_ovf_r;

  // Operand capture at accept and one iteration per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= {CNT_W{1'b0}};
      op_r       <= MD_MUL;
      a_raw_r    <= {XLEN{1'b0}};
      mag_b_r    <= {XLEN{1'b0}};
      hi_r       <= {XLEN{1'b0}};
      lo_r       <= {XLEN{1'b0}};
      neg_main_r <= 1'b0;
      neg_rem_r  <= 1'b0;
      div_zero_r <= 1'b0;
      div_ovf_r  <= 1'b0;
    end else if (start) begin
      cnt_r      <= {CNT_W{1'b0}};
      op_r       <= op_in;
      a_raw_r    <= a_in;
      mag_b_r    <= mag_b_s;
      hi_r       <= {XLEN{1'b0}};
      lo_r       <= mag_a_s;
      neg_main_r <= a_neg_s ^ b_neg_s;
      neg_rem_r  <= a_neg_s;
      div_zero_r <= div_zero_s;
      div_ovf_r  <= div_ovf_s;
    end else if (step) begin
      cnt_r <= cnt_r + CNT_W'(1);
      if (op_r[2]) begin
        if (!div_diff_s[XLEN]) begin
          hi_r <= div_diff_s[XLEN-1:0];
          lo_r <= {lo_r[XLEN-2:0], 1'b1};
        end else begin
          hi_r <= div_shift_s[XLEN-1:0];
          lo_r <= {lo_r[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_r <= mul_sum_s[XLEN:1];
        lo_r <= {mul_sum_s[0], lo_r[XLEN-1:1]};
      end
    end
  end

  // Final result selection with sign correction and divide corner cases
  always_comb begin
    result = {XLEN{1'b0}};
    case (op_r)
      MD_MUL: begin
        result = neg_main_r ? prod_neg_s[XLEN-1:0] : prod_s[XLEN-1:0];
      end
      MD_MULH, MD_MULHSU, MD_MULHU: begin
        result = neg_main_r ? prod_neg_s[2*XLEN-1:XLEN] : prod_s[2*XLEN-1:XLEN];
      end
      MD_DIV, MD_DIVU: begin
        if (div_zero_r) begin
          result = {XLEN{1'b1}};
        end else if (div_ovf_r) begin
          result = a_raw_r;
        end else begin
          result = neg_main_r ? neg_x(lo_r) : lo_r;
        end
      end
      MD_REM, MD_REMU: begin
        if (div_zero_r) begin
          result = a_raw_r;
        end else if (div_ovf_r) begin
          result = {XLEN{1'b0}};
        end else begin
          result = neg_rem_r ? neg_x(hi_r) : hi_r;
        end
      end
      default: result = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// ALU control decoder with an iterative M-extension sequencer.
// Ports: clk, rst_n (async active-low), bus (alu_ctrl_muldiv_if.slave):
// decode fields in, combinational Operation out, stall_o while an M op is
// unresolved, md_valid_o one-cycle pulse with md_result_o.
module alu_ctrl_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_ctrl_muldiv_if.slave   bus
);
  md_state_e       state_r, state_next_s;
  logic [3:0]      op_code_s;
  logic            md_op_s, accept_s, step_s, stall_s;
  logic            cnt_last_s, special_s;
  logic [XLEN-1:0] dp_result_s;
  logic            md_valid_r;
  logic [XLEN-1:0] md_result_r;

  // Base-ALU operation decode
  always_comb begin
    op_code_s = OP_ADD;
    case (bus.ALUOp)
      ALUOP_MEM:    op_code_s = OP_ADD;
      ALUOP_BRANCH: op_code_s = OP_CMP;
      ALUOP_JUMP:   op_code_s = OP_PASSB;
      ALUOP_RI: begin
        case (bus.Funct3)
          3'b000: begin
            // I-type has no Funct7, so only R-type may select SUB
            if (bus.RType && (bus.Funct7 == F7_ALT)) op_code_s = OP_SUB;
            else                                     op_code_s = OP_ADD;
          end
          3'b001: op_code_s = OP_SLL;
          3'b010: op_code_s = OP_SLT;
          3'b011: op_code_s = OP_SLTU;
          3'b100: op_code_s = OP_XOR;
          3'b101: begin
            // SRAI carries the same bit pattern in its immediate
            if (bus.Funct7 == F7_ALT) op_code_s = OP_SRA;
            else                      op_code_s = OP_SRL;
          end
          3'b110: op_code_s = OP_OR;
          3'b111: op_code_s = OP_AND;
          default: op_code_s = OP_ADD;
        endcase
      end
      default: op_code_s = OP_ADD;
    endcase
  end

  assign bus.Operation = OP_W'(op_code_s);
  assign md_op_s  = is_md_op(bus.ALUOp, bus.RType, bus.Funct7);
  assign accept_s = (state_r == ST_IDLE) && bus.valid_i && md_op_s && !bus.flush_i;

  // Sequencer next-state and iteration enable
  always_comb begin
    state_next_s = state_r;
    step_s       = 1'b0;
    if (bus.flush_i) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) state_next_s = bus.Funct3[2] ? ST_DIV : ST_MUL;
          else          state_next_s = ST_IDLE;
        end
        ST_MUL: begin
          if (cnt_last_s) state_next_s = ST_DONE;
          else            step_s       = 1'b1;
        end
        ST_DIV: begin
          // Corner cases are resolved in the first DIV cycle
          if (special_s || cnt_last_s) state_next_s = ST_DONE;
          else                         step_s       = 1'b1;
        end
        ST_DONE: state_next_s = ST_IDLE;
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // Pipeline stall; DONE releases the pipeline so the M op is not re-accepted
  always_comb begin
    stall_s = 1'b0;
    if (!rst_n || bus.flush_i) begin
      stall_s = 1'b0;
    end else if (accept_s || (state_r == ST_MUL) || (state_r == ST_DIV)) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  assign bus.stall_o     = stall_s;
  assign bus.md_valid_o  = md_valid_r;
  assign bus.md_result_o = md_result_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // Result registers loaded on entry to DONE, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_valid_r  <= 1'b0;
      md_result_r <= {XLEN{1'b0}};
    end else begin
      md_valid_r <= (state_next_s == ST_DONE);
      if (state_next_s == ST_DONE) md_result_r <= dp_result_s;
    end
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept_s),
    .step     (step_s),
    .op_in    (md_op_e'(bus.Funct3)),
    .a_in     (bus.src_a),
    .b_in     (bus.src_b),
    .cnt_last (cnt_last_s),
    .special  (special_s),
    .result   (dp_result_s)
  );

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
module tb_alu_ctrl_muldiv;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_ctrl_muldiv_if #(.XLEN(XLEN), .OP_W(4)) bus ();

  alu_ctrl_muldiv #(.XLEN(XLEN), .OP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [16:0] dec_tbl[15];  // {ALUOp, RType, Funct7, Funct3, expected Operation}

  // Reference M-extension semantics from wide signed/unsigned arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb, ub;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else if (ovf)   return a;
        else            return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else            return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        else if (ovf)   return 32'd0;
        else            return 32'(sa % sb);
      end
      default: begin
        if (b == 32'd0) return a;
        else            return a % b;
      end
    endcase
  endfunction

  task automatic drive_idle();
    bus.valid_i = 1'b0;
    bus.ALUOp   = 2'b00;
    bus.RType   = 1'b0;
    bus.Funct7  = 7'd0;
    bus.Funct3  = 3'd0;
    bus.src_a   = 32'd0;
    bus.src_b   = 32'd0;
    bus.flush_i = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    drive_idle();
  endtask

  // Present one M op, push its expected result, wait for md_valid_o and compare.
  // in_done: the op is presented during the previous op's DONE cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input bit in_done);
    int          edges;
    bit          seen;
    logic [31:0] exp_v;
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.ALUOp   = 2'b10;
    bus.RType   = 1'b1;
    bus.Funct7  = 7'b0000001;
    bus.Funct3  = op;
    bus.src_a   = a;
    bus.src_b   = b;
    bus.flush_i = 1'b0;
    exp_q.push_back(exp_res);
    #1;
    n_checks++;
    if (bus.stall_o !== (in_done ? 1'b0 : 1'b1)) begin
      n_fail++;
      $display("FAIL stall_on_present op=%0d in_done=%0d: got %b expected %b",
               op, in_done, bus.stall_o, !in_done);
    end
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.md_valid_o === 1'b1) begin
        seen = 1'b1;
      end else begin
        n_checks++;
        if (bus.stall_o !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_busy op=%0d edge=%0d: got %b expected 1", op, edges, bus.stall_o);
        end
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout op=%0d: no md_valid_o within 100 edges", op);
      if (exp_q.size() > 0) exp_v = exp_q.pop_front();
    end else begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.md_result_o !== exp_v) begin
        n_fail++;
        $display("FAIL result op=%0d a=%h b=%h: got %h expected %h", op, a, b, bus.md_result_o, exp_v);
      end
      n_checks++;
      if (bus.stall_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_in_done op=%0d: got %b expected 0", op, bus.stall_o);
      end
      if (exp_lat > 0) begin
        n_checks++;
        if (edges != exp_lat) begin
          n_fail++;
          $display("FAIL latency op=%0d: got %0d edges expected %0d", op, edges, exp_lat);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.valid_i = 1'b1;
    bus.ALUOp   = 2'b10;
    bus.RType   = 1'b1;
    bus.Funct7  = 7'b0000001;
    bus.Funct3  = 3'd0;
    bus.src_a   = 32'd3;
    bus.src_b   = 32'd4;
    bus.flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.stall_o); end
    n_checks++;
    if (bus.md_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.md_valid_o); end
    n_checks++;
    if (bus.md_result_o !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", bus.md_result_o); end
    bus.ALUOp = 2'b01;
    #1;
    n_checks++;
    if (bus.Operation !== 4'b1000) begin n_fail++; $display("FAIL reset_operation: got %b expected 1000", bus.Operation); end
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.md_valid_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got valid=%b stall=%b expected 0/0", bus.md_valid_o, bus.stall_o);
    end
  endtask

  task automatic test_decode();
    dec_tbl[0]  = {2'b00, 1'b0, 7'b0000000, 3'b000, 4'b0010};
    dec_tbl[1]  = {2'b01, 1'b0, 7'b0000000, 3'b000, 4'b1000};
    dec_tbl[2]  = {2'b11, 1'b0, 7'b0000000, 3'b000, 4'b1111};
    dec_tbl[3]  = {2'b10, 1'b1, 7'b0100000, 3'b000, 4'b0011};
    dec_tbl[4]  = {2'b10, 1'b0, 7'b0100000, 3'b000, 4'b0010};
    dec_tbl[5]  = {2'b10, 1'b1, 7'b0000000, 3'b000, 4'b0010};
    dec_tbl[6]  = {2'b10, 1'b1, 7'b0000000, 3'b001, 4'b1100};
    dec_tbl[7]  = {2'b10, 1'b1, 7'b0000000, 3'b010, 4'b0101};
    dec_tbl[8]  = {2'b10, 1'b1, 7'b0000000, 3'b011, 4'b0110};
    dec_tbl[9]  = {2'b10, 1'b1, 7'b0000000, 3'b100, 4'b0100};
    dec_tbl[10] = {2'b10, 1'b1, 7'b0000000, 3'b101, 4'b1101};
    dec_tbl[11] = {2'b10, 1'b0, 7'b0100000, 3'b101, 4'b1110};
    dec_tbl[12] = {2'b10, 1'b1, 7'b0000000, 3'b110, 4'b0001};
    dec_tbl[13] = {2'b10, 1'b1, 7'b0000000, 3'b111, 4'b0000};
    dec_tbl[14] = {2'b10, 1'b0, 7'b0000001, 3'b000, 4'b0010};
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.ALUOp   = dec_tbl[i][16:15];
      bus.RType   = dec_tbl[i][14];
      bus.Funct7  = dec_tbl[i][13:7];
      bus.Funct3  = dec_tbl[i][6:4];
      #1;
      n_checks++;
      if (bus.Operation !== dec_tbl[i][3:0]) begin
        n_fail++;
        $display("FAIL decode_op[%0d]: got %b expected %b", i, bus.Operation, dec_tbl[i][3:0]);
      end
      n_checks++;
      if (bus.stall_o !== 1'b0) begin
        n_fail++;
        $display("FAIL decode_stall[%0d]: got %b expected 0", i, bus.stall_o);
      end
    end
    idle_cycle();
  endtask

  task automatic test_mul();
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b0);
    idle_cycle();
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0);
    idle_cycle();
  endtask

  task automatic test_div_special();
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0);
    idle_cycle();
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2, 1'b0);
    idle_cycle();
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
    idle_cycle();
    run_op(3'd7, 32'd5, 32'd0, 32'd5, 2, 1'b0);
    idle_cycle();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.md_result_o !== 32'd5 || bus.md_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL result_hold: got result=%h valid=%b expected 00000005/0", bus.md_result_o, bus.md_valid_o);
    end
    run_op(3'd5, 32'd1000, 32'd7, 32'd142, 34, 1'b0);
    idle_cycle();
  endtask

  task automatic test_flush();
    bit seen;
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.ALUOp   = 2'b10;
    bus.RType   = 1'b1;
    bus.Funct7  = 7'b0000001;
    bus.Funct3  = 3'd5;
    bus.src_a   = 32'd1000;
    bus.src_b   = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    bus.valid_i = 1'b0;
    #1;
    n_checks++;
    if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", bus.stall_o); end
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b1;  // an M op now sees IDLE, so stall rises combinationally
    #1;
    n_checks++;
    if (bus.stall_o !== 1'b1) begin n_fail++; $display("FAIL flush_to_idle: got stall=%b expected 1", bus.stall_o); end
    bus.valid_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.md_valid_o === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_pulse: got pulse=%b expected 0", seen); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [2:0]  d_op[6] = '{3'd1, 3'd2, 3'd4, 3'd6, 3'd4, 3'd7};
    logic [31:0] d_a[6]  = '{32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd100};
    logic [31:0] d_b[6]  = '{32'd3, 32'd2, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd7};
    for (int i = 0; i < 14; i++) begin
      if (i < 6) begin
        op = d_op[i];
        a  = d_a[i];
        b  = d_b[i];
      end else begin
        op = 3'($urandom_range(0, 7));
        a  = $urandom;
        b  = (i == 10) ? 32'd0 : $urandom;
      end
      run_op(op, a, b, ref_md(op, a, b), 0, (i > 0));
    end
    idle_cycle();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    run_op(3'd0, 32'd6, 32'd7, 32'd42, 34, 1'b0);
    idle_cycle();
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.ALUOp   = 2'b10;
    bus.RType   = 1'b1;
    bus.Funct7  = 7'b0000001;
    bus.Funct3  = 3'd0;
    bus.src_a   = 32'd9;
    bus.src_b   = 32'd9;
    repeat (5) @(posedge clk);
    #1;
    rst_n     = 1'b0;
    bus.ALUOp = 2'b11;
    #1;
    n_checks++;
    if (bus.stall_o !== 1'b0 || bus.md_valid_o !== 1'b0 || bus.md_result_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got stall=%b valid=%b result=%h expected 0/0/0",
               bus.stall_o, bus.md_valid_o, bus.md_result_o);
    end
    n_checks++;
    if (bus.Operation !== 4'b1111) begin n_fail++; $display("FAIL reset_mid_operation: got %b expected 1111", bus.Operation); end
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        if (bus.md_valid_o === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_pulse: got pulse=%b expected 0", seen); end
    end
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b0);
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mul();
    test_div_special();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_muldiv.md
ALU_CTRL_MULDIV -- requirements
Module: alu_ctrl_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 32 or 64.
REQ-002 SHALL have parameter OP_W, default 4, width of the Operation code.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port valid_i  input  1  the decode inputs carry a live instruction this cycle.
REQ-006 SHALL have port ALUOp  input  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI.
REQ-007 SHALL have port RType  input  1  the instruction is R-type, so Funct7 is real.
REQ-008 SHALL have port Funct7  input  7  instruction bits 31:25.
REQ-009 SHALL have port Funct3  input  3  instruction bits 14:12.
REQ-010 SHALL have port src_a / src_b  input  XLEN each  M-extension operands.
REQ-011 SHALL have port flush_i  input  1  abort any M operation in flight.
REQ-012 SHALL have port Operation  output  OP_W  combinational base-ALU select.
REQ-013 SHALL have port stall_o  output  1  hold the pipeline while an M op is unresolved.
REQ-014 SHALL have port md_valid_o  output  1  one-cycle pulse; md_result_o is valid.
REQ-015 SHALL have port md_result_o  output  XLEN  M-extension result.

Function
REQ-016 Operation SHALL decode combinationally as follows:
- AND 0000, OR 0001, ADD 0010, SUB 0011, XOR 0100, SLT 0101, SLTU 0110.
- BEQ/compare 1000, SLL 1100, SRL 1101, SRA 1110, LUI pass-B 1111.
- ALUOp 00 gives ADD; 01 gives 1000; 11 gives 1111.
- SUB only when RType=1 and Funct7=0100000; SRA when Funct3=101 and Funct7=0100000 in either R or I form.
REQ-017 An M op SHALL be ALUOp=10, RType=1, Funct7=0000001; Funct3 selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU (000..111).
REQ-018 The FSM SHALL have states IDLE, MUL, DIV and DONE; reset state is IDLE.
REQ-019 In IDLE, valid_i with an M op SHALL latch the operands and Funct3 and go to MUL (Funct3[2]=0) or DIV (Funct3[2]=1) on the next edge.
REQ-020 MUL and DIV SHALL iterate exactly XLEN cycles using a log2(XLEN)+1-bit counter:
- MUL uses shift-add on magnitudes.
- DIV uses restoring division on magnitudes.
REQ-021 Sign handling SHALL convert signed operands to magnitudes at accept and negate the result in DONE according to the RISC-V rules.
REQ-022 After the last iteration, the FSM SHALL enter DONE for one cycle with md_valid_o=1 and md_result_o driven, then return to IDLE; total latency is XLEN+2 edges from accept.
REQ-023 MUL SHALL return the low XLEN bits of the product; MULH, MULHSU and MULHU SHALL return the high XLEN bits with ss, su and uu signedness respectively.
REQ-024 Divide by zero SHALL skip iteration and go straight to DONE:
- quotient all ones;
- remainder = dividend.
REQ-025 Signed overflow (most-negative / -1) SHALL skip iteration and go straight to DONE:
- quotient = dividend;
- remainder 0.
REQ-026 stall_o SHALL be asserted:
- combinationally when valid_i carries an M op in IDLE;
- in every MUL and DIV cycle.
It SHALL be 0 in DONE and 0 for non-M instructions.
REQ-027 An M op presented while in DONE SHALL NOT be re-accepted; the pipeline advances in that cycle.
REQ-028 flush_i SHALL take precedence over every other condition:
- the FSM returns to IDLE on the next edge;
- no md_valid_o pulse is produced;
- stall_o is forced to 0 in that cycle.
REQ-029 md_result_o SHALL hold its last value outside DONE.

Reset
REQ-030 While rst_n=0, the state SHALL be IDLE and the counter, operand registers and md_result_o SHALL be 0.
REQ-031 While rst_n=0, md_valid_o and stall_o SHALL be 0, and Operation SHALL still follow its inputs.
REQ-032 Reset asserted mid-iteration SHALL abandon the operation with no md_valid_o pulse after release.

Structure
REQ-033 A shared package alu_pkg SHALL hold:
- the Operation code constants;
- the ALUOp constants;
- the M-op Funct3 enum;
- the FSM state typedef.
REQ-034 The iterative datapath SHALL be one sub-module, muldiv_iter, with the FSM and decode kept in alu_ctrl_muldiv.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- ALUOp=10, RType=1, Funct7=0100000, Funct3=000 -> Operation=0011, stall_o=0.
- MUL with src_a=7, src_b=-3 (XLEN=32) -> md_valid_o exactly 34 edges after accept, md_result_o=0xFFFFFFEB.
- MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> md_result_o=0xFFFFFFFE.
- DIV with 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, md_valid_o on the 2nd edge after accept; REM of the same operands -> 0.
- DIVU with 5 / 0 -> 0xFFFFFFFF; REMU with 5 / 0 -> 5.
- flush_i asserted in the 10th DIV cycle -> IDLE next edge, no md_valid_o pulse; rst_n dropped mid-MUL -> all outputs 0 immediately.
